// File: rtl/sort_serializer_pkg.sv
// Shared definitions for the sort network: serializer FSM encoding and a
// counter-width helper.
package sort_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Bits needed to hold 0..depth-1, never less than one.
  function automatic int cnt_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sort_serializer.sv
// Parallel-load, MSB-first multi-lane serializer with a fixed idle gap
// between words; all outputs come straight from flops.
module sort_serializer
  import sort_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic [LANES*WIDTH-1:0] load_data_i,
  output logic [LANES-1:0]       bit_o,
  output logic                   run_o,
  output logic                   swap_o,
  output logic                   done_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP - 1);

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [GW-1:0] gap_r, gap_s;
  logic          run_r, run_s;
  logic          done_r, done_s;
  logic          ready_r, ready_s;
  logic          xfer_s;
  logic          load_s, shift_s, clear_s;

  assign xfer_s = load_valid_i & ready_r;

  // Next-state and lane-control decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    gap_s   = gap_r;
    run_s   = 1'b0;
    done_s  = 1'b0;
    ready_s = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    clear_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_s = ST_SHIFT;
          cnt_s   = CNT_TOP;
          run_s   = 1'b1;
          load_s  = 1'b1;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s   = cnt_r - CW'(1);
          run_s   = 1'b1;
          shift_s = 1'b1;
          done_s  = (cnt_r == CW'(1));
        end else begin
          // Bit 0 was just shown; the gap holds the lanes low.
          state_s = ST_GAP;
          gap_s   = GAP_TOP;
          clear_s = 1'b1;
          ready_s = (GAP_TOP == {GW{1'b0}});
        end
      end
      ST_GAP: begin
        if (gap_r != {GW{1'b0}}) begin
          gap_s   = gap_r - GW'(1);
          ready_s = (gap_r == GW'(1));
        end else if (xfer_s) begin
          state_s = ST_SHIFT;
          cnt_s   = CNT_TOP;
          run_s   = 1'b1;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        gap_s   = {GW{1'b0}};
        clear_s = 1'b1;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      gap_r   <= {GW{1'b0}};
      run_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      gap_r   <= gap_s;
      run_r   <= run_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  // The MSB goes straight to the output flop; the shift register keeps the rest.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-2:0] sreg_r;
    logic             bit_r;

    // Per-lane load / shift / clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sreg_r <= {(WIDTH-1){1'b0}};
        bit_r  <= 1'b0;
      end else if (load_s) begin
        sreg_r <= load_data_i[l*WIDTH +: WIDTH-1];
        bit_r  <= load_data_i[l*WIDTH + WIDTH - 1];
      end else if (shift_s) begin
        sreg_r <= sreg_r << 1'b1;
        bit_r  <= sreg_r[WIDTH-2];
      end else if (clear_s) begin
        sreg_r <= {(WIDTH-1){1'b0}};
        bit_r  <= 1'b0;
      end else begin
        sreg_r <= sreg_r;
        bit_r  <= bit_r;
      end
    end

    assign bit_o[l] = bit_r;
  end

  assign load_ready_o = ready_r;
  assign run_o        = run_r;
  assign done_o       = done_r;
  assign swap_o       = 1'b0;

endmodule

// File: tb/tb_sort_serializer.sv
// Directed bench: one serializer with the default shape and one with GAP=3,
// single lane.
module tb_sort_serializer;

  logic        clk;
  logic        rst_n;
  logic        lv_a, lr_a, run_a, swap_a, done_a;
  logic [31:0] ld_a;
  logic [3:0]  bo_a;
  logic        lv_b, lr_b, run_b, swap_b, done_b;
  logic [7:0]  ld_b;
  logic [0:0]  bo_b;

  int cmp_cnt = 0;
  int err_cnt = 0;

  sort_serializer #(.WIDTH(8), .LANES(4), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid_i(lv_a), .load_ready_o(lr_a),
    .load_data_i(ld_a), .bit_o(bo_a), .run_o(run_a), .swap_o(swap_a), .done_o(done_a)
  );

  sort_serializer #(.WIDTH(8), .LANES(1), .GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid_i(lv_b), .load_ready_o(lr_b),
    .load_data_i(ld_b), .bit_o(bo_b), .run_o(run_b), .swap_o(swap_b), .done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer a vector while ready is high; valid drops after the transfer edge.
  task automatic start_word(input logic [31:0] vec);
    ld_a = vec;
    lv_a = 1'b1;
    @(posedge clk);
    #1 lv_a = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] vec, input logic junk_en);
    logic [3:0] exp_bits;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_bits = {vec[31-i], vec[23-i], vec[15-i], vec[7-i]};
      check_eq({tag, "_run"}, 32'(run_a), 32'd1);
      check_eq({tag, "_bit"}, 32'(bo_a), 32'(exp_bits));
      check_eq({tag, "_done"}, 32'(done_a), (i == 7) ? 32'd1 : 32'd0);
      check_eq({tag, "_rdy"}, 32'(lr_a), 32'd0);
      if (junk_en) begin
        if (i < 4) begin
          lv_a = 1'b1;
          ld_a = 32'hDEAD_BEEF;
        end else begin
          lv_a = 1'b0;
        end
      end
    end
  endtask

  task automatic check_gap_a(input string tag, input logic exp_rdy);
    @(negedge clk);
    check_eq({tag, "_run"}, 32'(run_a), 32'd0);
    check_eq({tag, "_bit"}, 32'(bo_a), 32'd0);
    check_eq({tag, "_done"}, 32'(done_a), 32'd0);
    check_eq({tag, "_rdy"}, 32'(lr_a), 32'(exp_rdy));
  endtask

  task automatic expect_word_b(input string tag, input logic [7:0] vec);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq({tag, "_run"}, 32'(run_b), 32'd1);
      check_eq({tag, "_bit"}, 32'(bo_b), 32'(vec[7-i]));
      check_eq({tag, "_done"}, 32'(done_b), (i == 7) ? 32'd1 : 32'd0);
      check_eq({tag, "_rdy"}, 32'(lr_b), 32'd0);
    end
  endtask

  task automatic check_gap_b(input string tag);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      check_eq({tag, "_run"}, 32'(run_b), 32'd0);
      check_eq({tag, "_bit"}, 32'(bo_b), 32'd0);
      check_eq({tag, "_rdy"}, 32'(lr_b), (g == 2) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    lv_a  = 1'b0;
    ld_a  = 32'h0;
    lv_b  = 1'b0;
    ld_b  = 8'h0;

    @(negedge clk);
    check_eq("rst_run", 32'(run_a), 32'd0);
    check_eq("rst_bit", 32'(bo_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_rdy", 32'(lr_a), 32'd0);
    check_eq("rst_swap", 32'(swap_a), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_rdy_pre", 32'(lr_a), 32'd0);
    @(negedge clk);
    check_eq("rel_rdy", 32'(lr_a), 32'd1);

    // Long idle: nothing moves, ready stays up.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_run", 32'(run_a), 32'd0);
      check_eq("idle_bit", 32'(bo_a), 32'd0);
      check_eq("idle_done", 32'(done_a), 32'd0);
      check_eq("idle_rdy", 32'(lr_a), 32'd1);
    end

    // Lanes 3..0 = A5, 3C, FF, 00.
    start_word(32'hA53C_FF00);
    expect_word("w0", 32'hA53C_FF00, 1'b0);
    check_gap_a("w0_gap", 1'b1);
    @(negedge clk);
    check_eq("w0_idle_run", 32'(run_a), 32'd0);
    check_eq("w0_idle_rdy", 32'(lr_a), 32'd1);

    // Back-to-back with valid held high; the second vector sits on the bus
    // during the first word and must only be taken in the gap cycle.
    ld_a = 32'h1234_5678;
    lv_a = 1'b1;
    @(posedge clk);
    #1 ld_a = 32'h9ABC_DEF0;
    expect_word("b2b0", 32'h1234_5678, 1'b0);
    check_gap_a("b2b_gap", 1'b1);
    @(posedge clk);
    #1 lv_a = 1'b0;
    expect_word("b2b1", 32'h9ABC_DEF0, 1'b0);
    check_gap_a("b2b1_gap", 1'b1);

    // Junk offered while not ready must be ignored.
    @(negedge clk);
    start_word(32'h0F1E_2D3C);
    expect_word("junk", 32'h0F1E_2D3C, 1'b1);
    check_gap_a("junk_gap", 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("junk_idle_run", 32'(run_a), 32'd0);
      check_eq("junk_idle_rdy", 32'(lr_a), 32'd1);
    end

    // Reset while bit 4 is on the lanes.
    start_word(32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("pre_rst_bit", 32'(bo_a), 32'hF);
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_run", 32'(run_a), 32'd0);
    check_eq("mid_rst_bit", 32'(bo_a), 32'd0);
    check_eq("mid_rst_done", 32'(done_a), 32'd0);
    check_eq("mid_rst_rdy", 32'(lr_a), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("hold_rst_done", 32'(done_a), 32'd0);
      check_eq("hold_rst_run", 32'(run_a), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel2_rdy_pre", 32'(lr_a), 32'd0);
    check_eq("rel2_run", 32'(run_a), 32'd0);
    @(negedge clk);
    check_eq("rel2_rdy", 32'(lr_a), 32'd1);
    start_word(32'h0000_0081);
    expect_word("post_rst", 32'h0000_0081, 1'b0);
    check_gap_a("post_rst_gap", 1'b1);

    // GAP=3 instance, back-to-back.
    @(negedge clk);
    check_eq("b_rdy", 32'(lr_b), 32'd1);
    check_eq("b_swap", 32'(swap_b), 32'd0);
    ld_b = 8'hC3;
    lv_b = 1'b1;
    @(posedge clk);
    #1 ld_b = 8'h5A;
    expect_word_b("b0", 8'hC3);
    check_gap_b("b0_gap");
    @(posedge clk);
    #1 lv_b = 1'b0;
    expect_word_b("b1", 8'h5A);
    check_gap_b("b1_gap");
    @(negedge clk);
    check_eq("b_idle_run", 32'(run_b), 32'd0);
    check_eq("b_idle_rdy", 32'(lr_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per word, min 2.
REQ-002 SHALL have parameter LANES, default 4: parallel serial lanes, min 1.
REQ-003 SHALL have parameter GAP, default 1: run-low cycles between words, min 1.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_valid_i  in  1  word vector offered.
REQ-007 SHALL have port load_ready_o  out  1  block accepts vector this cycle.
REQ-008 SHALL have port load_data_i  in  LANES*WIDTH  lane i = load_data_i[i*WIDTH +: WIDTH].
REQ-009 SHALL have port bit_o  out  LANES  serial bit per lane, MSB first.
REQ-010 SHALL have port run_o  out  1  high while word bits are valid on bit_o.
REQ-011 SHALL have port swap_o  out  1  swap-chain seed for the first compare stage.
REQ-012 SHALL have port done_o  out  1  one-cycle pulse on last bit of a word.

Function
REQ-013 SHALL use FSM states IDLE, SHIFT, GAP.
REQ-014 SHALL transfer a vector on a rising edge where load_valid_i and load_ready_o are both high.
REQ-015 SHALL drive load_ready_o high in IDLE and in the final GAP cycle, low otherwise.
REQ-016 SHALL, on a transfer, capture load_data_i into a LANES x WIDTH shift register and enter SHIFT.
REQ-017 SHALL register all outputs: run_o rises the cycle after the transfer edge and stays high exactly WIDTH cycles.
REQ-018 SHALL present bit WIDTH-1 of each lane on bit_o in the first SHIFT cycle, then bit WIDTH-2, down to bit 0, one bit per cycle.
REQ-019 SHALL use a bit counter of ceil(log2(WIDTH)) bits, loaded with WIDTH-1 and decremented per SHIFT cycle, with no wrap past 0.
REQ-020 SHALL assert done_o only in the SHIFT cycle presenting bit 0.
REQ-021 SHALL go from SHIFT to GAP after bit 0 and hold run_o and bit_o low for exactly GAP cycles.
REQ-022 SHALL, on a transfer in the final GAP cycle, go directly to SHIFT: back-to-back period is WIDTH+GAP cycles.
REQ-023 SHALL, without a transfer in the final GAP cycle, return to IDLE with run_o low.
REQ-024 SHALL hold swap_o at 0 at all times.
REQ-025 SHALL ignore load_data_i and load_valid_i whenever load_ready_o is low.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, run_o=0, bit_o=0, done_o=0, load_ready_o=0, and clear the shift register and counter.
REQ-027 SHALL drive load_ready_o high on the first rising edge after rst_n deasserts.
REQ-028 SHALL discard a word interrupted by reset; it is never resumed.

Structure
REQ-029 SHALL place FSM state encoding and the counter-width function in the shared sort package used by the sort network.
REQ-030 SHALL be a single module with no sub-modules; the per-lane shift register is a generate loop.

Verification
REQ-031 SHALL cover: WIDTH=8, LANES=4, GAP=1, lanes3..0 = A5,3C,FF,00 -> run_o high 8 cycles; lane3 = 1,0,1,0,0,1,0,1; lane2 = 0,0,1,1,1,1,0,0; lane1 all 1; lane0 all 0; done_o on cycle 8.
REQ-032 SHALL cover: load_valid_i held high with two vectors -> run_o low exactly 1 cycle between words, period 9 cycles, load_ready_o high only in the gap cycle.
REQ-033 SHALL cover: load_valid_i low for 20 cycles -> run_o, bit_o, done_o stay 0 and load_ready_o stays 1.
REQ-034 SHALL cover: rst_n low during bit 4 -> run_o and bit_o go 0 immediately, with no done_o; after release, vector 81 on lane0 serializes 1,0,0,0,0,0,0,1.
REQ-035 SHALL cover: GAP=3, back-to-back vectors -> run_o low exactly 3 cycles between words, period 11 cycles.
REQ-036 SHALL cover: vector offered while load_ready_o is low -> the vector is not captured, and the serialized words are unchanged.
